// File: rtl/serial_alu_pkg.sv
// Shared opcode encodings and sequencer state type for the bit-serial ALU.
package serial_alu_pkg;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_AND = 2'b01;
  localparam logic [1:0] ALU_OP_NOR = 2'b10;
  localparam logic [1:0] ALU_OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/serial_alu_seq.sv
// Bit-serial WIDTH-bit ALU sequencer around an external 1-bit slice; optional zero flag via SERIAL_ALU_ZFLAG_EN.
// Latency: done pulses WIDTH+1 cycles after start; start is ignored while busy, accepted again in DONE.
module serial_alu_seq
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
`ifdef SERIAL_ALU_ZFLAG_EN
  output logic             zero,
`endif
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_c,
  output logic [1:0]       alu_ctr,
  input  logic             alu_d,
  input  logic             alu_e
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [1:0]       op_r;
  logic             carry, carry_nxt;
  logic [CW-1:0]    count;
  logic             last_bit, accept;
`ifdef SERIAL_ALU_ZFLAG_EN
  logic             any_d;
`endif

  assign accept    = start && (state != RUN);
  assign last_bit  = (count == CW'(WIDTH - 1));
  // Only add propagates a carry; other ops keep the carry register cleared.
  assign carry_nxt = (op_r == ALU_OP_ADD) ? alu_e : 1'b0;

  assign alu_a   = busy & a_sh[0];
  assign alu_b   = busy & b_sh[0];
  assign alu_c   = busy & carry;
  assign alu_ctr = op_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      op_r   <= ALU_OP_ADD;
      carry  <= 1'b0;
      count  <= '0;
      result <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ALU_ZFLAG_EN
      any_d  <= 1'b0;
      zero   <= 1'b0;
`endif
    end else if (accept) begin
      a_sh  <= opa;
      b_sh  <= opb;
      op_r  <= op;
      carry <= 1'b0;
      count <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ALU_ZFLAG_EN
      any_d <= 1'b0;
`endif
    end else if (state == RUN) begin
      // LSB is processed first, so each new slice bit enters at the MSB.
      result <= {alu_d, result[WIDTH-1:1]};
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      carry  <= carry_nxt;
      count  <= count + CW'(1);
`ifdef SERIAL_ALU_ZFLAG_EN
      any_d  <= any_d | alu_d;
`endif
      if (last_bit) begin
        cout <= carry_nxt;
`ifdef SERIAL_ALU_ZFLAG_EN
        zero <= ~(any_d | alu_d);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_alu_seq.sv
// Scoreboard bench for serial_alu_seq with a behavioural 1-bit slice wired to its alu_* ports.
module tb_serial_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] op;
  logic [7:0] opa, opb;
  logic       busy, done, cout;
  logic [7:0] result;
`ifdef SERIAL_ALU_ZFLAG_EN
  logic       zero;
`endif
  logic       alu_a, alu_b, alu_c, alu_d, alu_e;
  logic [1:0] alu_ctr;

  typedef struct packed {
    logic [7:0] res;
    logic       co;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   lat, bn;

  always #5 clk = ~clk;

  serial_alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result(result), .cout(cout),
`ifdef SERIAL_ALU_ZFLAG_EN
    .zero(zero),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_ctr(alu_ctr),
    .alu_d(alu_d), .alu_e(alu_e)
  );

  // 1-bit ALU slice: d is the result bit, e the carry out (only meaningful for add).
  always_comb begin
    alu_d = 1'b0;
    alu_e = 1'b0;
    case (alu_ctr)
      2'b00: begin
        alu_d = alu_a ^ alu_b ^ alu_c;
        alu_e = (alu_a & alu_b) | (alu_c & (alu_a ^ alu_b));
      end
      2'b01: alu_d = alu_a & alu_b;
      2'b10: alu_d = ~(alu_a | alu_b);
      default: alu_d = alu_a ^ alu_b;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'(0));
      end else begin
        mon_e = sb.pop_front();
        chk("result", 32'(result), 32'(mon_e.res));
        chk("cout", 32'(cout), 32'(mon_e.co));
`ifdef SERIAL_ALU_ZFLAG_EN
        chk("zero", 32'(zero), 32'(mon_e.res == 8'h00));
`endif
      end
    end
  end

  task automatic launch(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] r, input logic c, input bit push);
    exp_t e;
    e.res = r;
    e.co  = c;
    if (push) sb.push_back(e);
    op    = o;
    opa   = a;
    opb   = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int l, output int bcnt);
    l    = 0;
    bcnt = 0;
    do begin
      @(negedge clk);
      l++;
      if (busy) bcnt++;
    end while (!done && l < 40);
    if (!done) chk("done_timeout", 32'(done), 32'(1));
  endtask

  logic [1:0] v_op [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
  logic [7:0] v_a  [6] = '{8'h5A, 8'hFF, 8'hF0, 8'hF0, 8'hAA, 8'h80};
  logic [7:0] v_b  [6] = '{8'h3C, 8'h01, 8'h3C, 8'h0F, 8'h0F, 8'h81};
  logic [7:0] v_r  [6] = '{8'h96, 8'h00, 8'h30, 8'h00, 8'hA5, 8'h01};
  logic       v_c  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    opa   = 8'h00;
    opb   = 8'h00;
    #12;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_result", 32'(result), 32'(0));
    chk("rst_cout", 32'(cout), 32'(0));
    chk("rst_alu_a", 32'(alu_a), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      launch(v_op[i], v_a[i], v_b[i], v_r[i], v_c[i], 1'b1);
      wait_done(lat, bn);
      chk("latency", 32'(lat), 32'(9));
      chk("busy_cycles", 32'(bn), 32'(8));
      @(negedge clk);
    end
    // Last vector left result=0x01, cout=1; both must persist in IDLE.
    repeat (3) @(negedge clk);
    chk("hold_result", 32'(result), 32'(8'h01));
    chk("hold_cout", 32'(cout), 32'(1));
    chk("idle_busy", 32'(busy), 32'(0));

    // start pulsed mid-run with different operands must be ignored.
    launch(2'b00, 8'h12, 8'h34, 8'h46, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    op    = 2'b11;
    opa   = 8'hFF;
    opb   = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bn);
    repeat (12) @(negedge clk);

    // start held during DONE: second op accepted back-to-back.
    launch(2'b01, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b1);
    wait_done(lat, bn);
    launch(2'b11, 8'hAA, 8'h0F, 8'hA5, 1'b0, 1'b1);
    wait_done(lat, bn);
    chk("b2b_latency", 32'(lat), 32'(9));
    chk("b2b_busy_cycles", 32'(bn), 32'(8));
    @(negedge clk);

    // Reset in RUN cycle 4 aborts immediately with no done pulse.
    launch(2'b00, 8'h80, 8'h81, 8'h00, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_result", 32'(result), 32'(0));
    chk("abort_cout", 32'(cout), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    launch(2'b00, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b1);
    wait_done(lat, bn);
    chk("post_rst_latency", 32'(lat), 32'(9));

    repeat (5) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
